// File: rtl/cfg_sram_pkg.sv
// -----------------------------------------------------------------------------
// cfg_sram_pkg
// Shared definitions for the configuration SRAM array and its scan controller.
//
// Contents:
//   scan_state_t : scan frame FSM state (IDLE, SHIFT, DONE)
//   CRC_POLY     : CRC-8 generator polynomial (x^8 + x^2 + x + 1, low byte)
//   CRC_SEED     : CRC register value at the start of every scan frame
//   crc8_step    : one MSB-first serial CRC-8 update for a single input bit
// -----------------------------------------------------------------------------
package cfg_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_t;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_SEED = 8'h00;

    // MSB-first serial update: the bit leaving crc[7] is combined with the
    // incoming bit; when that feedback is set the polynomial is folded back in.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic       bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage : cfg_sram_pkg

// File: rtl/cfg_sram_array_if.sv
// -----------------------------------------------------------------------------
// cfg_sram_array_if
// Bundles the read, write, scan and status signals of cfg_sram_array.
//
// Parameters:
//   DATA_WIDTH : bits per configuration word
//   ADDR_WIDTH : word address bits (DEPTH = 2**ADDR_WIDTH)
//
// Signals (direction seen from the array, i.e. the slave modport):
//   raddr/rdata          : combinational word read port
//   we/waddr/wdata       : word write port
//   scan_en/scan_in      : serial shift request and data
//   scan_out             : chain tail bit
//   cfg_lock             : freezes the array and the scan frame
//   scan_busy/scan_done  : frame in progress / one-cycle completion pulse
//   crc_out              : CRC-8 of the bits shifted in during the frame
//   dbg_state/dbg_count  : scan FSM state and shift counter, for observation
//
// Transfer semantics: there is no valid/ready pairing. A request is taken on
// the rising clock edge at which it is presented; cfg_lock high blocks every
// request, otherwise we wins over scan_en. An accepted write or shift always
// completes in that single cycle, so no back-pressure signal exists.
// -----------------------------------------------------------------------------
interface cfg_sram_array_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    import cfg_sram_pkg::*;

    localparam int TOTAL_BITS = (2 ** ADDR_WIDTH) * DATA_WIDTH;
    localparam int CNT_W      = $clog2(TOTAL_BITS);

    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  scan_en;
    logic                  scan_in;
    logic                  scan_out;
    logic                  cfg_lock;
    logic                  scan_busy;
    logic                  scan_done;
    logic [7:0]            crc_out;
    scan_state_t           dbg_state;
    logic [CNT_W-1:0]      dbg_count;

    modport master (
        output raddr, we, waddr, wdata, scan_en, scan_in, cfg_lock,
        input  rdata, scan_out, scan_busy, scan_done, crc_out,
               dbg_state, dbg_count
    );

    modport slave (
        input  raddr, we, waddr, wdata, scan_en, scan_in, cfg_lock,
        output rdata, scan_out, scan_busy, scan_done, crc_out,
               dbg_state, dbg_count
    );

endinterface : cfg_sram_array_if

// File: rtl/cfg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// cfg_scan_ctrl
// Tracks scan frames over the configuration chain: FSM, shift counter and the
// running CRC-8 of the bits entering the chain head.
//
// Parameters:
//   TOTAL_BITS : frame length in shifts (>= 2)
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_shift    : a shift is accepted by the array on this edge
//   i_scan_in  : bit entering the chain head with that shift
//   o_busy     : frame in progress (state SHIFT)
//   o_done     : one-cycle pulse after the last shift of a frame (state DONE)
//   o_crc      : CRC-8 of the current frame, or of the last finished frame
//   o_state    : FSM state, for observation
//   o_count    : shifts taken so far in the current frame
// -----------------------------------------------------------------------------
module cfg_scan_ctrl
    import cfg_sram_pkg::*;
#(
    parameter  int TOTAL_BITS = 64,
    localparam int CNT_W      = $clog2(TOTAL_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic             i_scan_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_crc,
    output scan_state_t      o_state,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [7:0]       r_crc;
    logic [7:0]       w_crc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_crc   <= CRC_SEED;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_crc   <= w_crc_nxt;
        end
    end

    // Idle cycles inside a frame hold everything, so a frame may be paused
    // for any length of time. The CRC is left untouched in IDLE and DONE so
    // the result of the last frame stays visible until a new frame starts.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_crc_nxt   = r_crc;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_shift) begin
                    w_state_nxt = ST_SHIFT;
                    w_count_nxt = ONE_CNT;
                    w_crc_nxt   = crc8_step(CRC_SEED, i_scan_in);
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (i_shift) begin
                    w_crc_nxt = crc8_step(r_crc, i_scan_in);
                    if (r_count == LAST_CNT) begin
                        w_state_nxt = ST_DONE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + ONE_CNT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_crc_nxt   = CRC_SEED;
            end
        endcase
    end

    assign o_busy  = (r_state == ST_SHIFT);
    assign o_done  = (r_state == ST_DONE);
    assign o_crc   = r_crc;
    assign o_state = r_state;
    assign o_count = r_count;

endmodule : cfg_scan_ctrl

// File: rtl/cfg_sram_array.sv
// -----------------------------------------------------------------------------
// cfg_sram_array
// Register-based configuration memory that can be written word by word or
// loaded/unloaded as one serial scan chain.
//
// Parameters:
//   DATA_WIDTH : bits per word (>= 1)
//   ADDR_WIDTH : word address bits, DEPTH = 2**ADDR_WIDTH
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset, clears array and scan frame
//   bus  : cfg_sram_array_if slave modport (read, write, scan, status)
//
// Chain order: word0 bit0 is the head (scan_in enters here), word(DEPTH-1)
// bit(DATA_WIDTH-1) is the tail (drives scan_out). A shift moves every bit one
// place toward the tail, so the top bit of word d becomes bit 0 of word d+1.
// -----------------------------------------------------------------------------
module cfg_sram_array
    import cfg_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    cfg_sram_array_if.slave bus
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int TOTAL_BITS = DEPTH * DATA_WIDTH;
    localparam int CNT_W      = $clog2(TOTAL_BITS);

    // Packed so that flat bit (d*DATA_WIDTH + b) is word d bit b, which is
    // exactly the chain position of that bit.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [TOTAL_BITS-1:0]            w_flat;
    logic [TOTAL_BITS-1:0]            w_shifted;
    logic                             w_write;
    logic                             w_shift;

    logic                             w_busy;
    logic                             w_done;
    logic [7:0]                       w_crc;
    scan_state_t                      w_state;
    logic [CNT_W-1:0]                 w_count;

    assign w_flat    = r_mem;
    assign w_shifted = {w_flat[TOTAL_BITS-2:0], bus.scan_in};

    // Lock blocks everything; a write pre-empts a shift requested together
    // with it, and that shift is simply dropped (not deferred).
    assign w_write = bus.we & ~bus.cfg_lock;
    assign w_shift = bus.scan_en & ~bus.we & ~bus.cfg_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (w_write) begin
            r_mem[bus.waddr] <= bus.wdata;
        end else if (w_shift) begin
            r_mem <= w_shifted;
        end
    end

    // Read port shows the stored value; a write in the same cycle is only
    // visible after the edge.
    assign bus.rdata    = r_mem[bus.raddr];
    assign bus.scan_out = w_flat[TOTAL_BITS-1];

    cfg_scan_ctrl #(
        .TOTAL_BITS (TOTAL_BITS)
    ) u_scan_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_shift   (w_shift),
        .i_scan_in (bus.scan_in),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_crc     (w_crc),
        .o_state   (w_state),
        .o_count   (w_count)
    );

    assign bus.scan_busy = w_busy;
    assign bus.scan_done = w_done;
    assign bus.crc_out   = w_crc;
    assign bus.dbg_state = w_state;
    assign bus.dbg_count = w_count;

endmodule : cfg_sram_array

// File: tb/tb_cfg_sram_array.sv
// -----------------------------------------------------------------------------
// tb_cfg_sram_array
// Self-checking bench for cfg_sram_array with a word-level reference model and
// a CRC computed by polynomial long division over the frame's bit list.
// -----------------------------------------------------------------------------
module tb_cfg_sram_array;
    import cfg_sram_pkg::*;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TOTAL = 64;
    localparam int CW    = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cfg_sram_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cfg_sram_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_frame[$];
    bit            m_active;
    bit            m_done;
    logic [DW-1:0] exp_q[$];

    // Remainder of (frame * x^8) mod (x^8 + x^2 + x + 1), frame MSB first.
    function automatic logic [7:0] crc_div(input bit q[$]);
        bit         m[$];
        logic [8:0] p;
        logic [7:0] r;
        int         n;
        p = 9'h107;
        m = q;
        n = q.size();
        for (int k = 0; k < 8; k++) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i])
                for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ p[8-j];
        for (int j = 0; j < 8; j++) r[7-j] = m[n+j];
        return r;
    endfunction

    function automatic int m_count();
        return m_active ? m_frame.size() : 0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < DEPTH; d++) m_mem[d] = '0;
        m_frame.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
    endfunction

    function automatic void model_step(bit we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                       bit sen, bit sin, bit lock);
        bit   acc;
        logic carry;
        logic nc;
        acc = sen && !we && !lock;
        if (!lock && we) begin
            m_mem[wa] = wd;
        end else if (acc) begin
            carry = sin;
            for (int d = 0; d < DEPTH; d++) begin
                nc       = m_mem[d][DW-1];
                m_mem[d] = {m_mem[d][DW-2:0], carry};
                carry    = nc;
            end
        end
        if (acc) begin
            if (!m_active) begin
                m_frame.delete();
                m_active = 1'b1;
            end
            m_frame.push_back(sin);
            m_done = 1'b0;
            if (m_frame.size() == TOTAL) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.scan_en  = 1'b0;
        bus.scan_in  = 1'b0;
        bus.cfg_lock = 1'b0;
    endtask

    task automatic cycle(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit sen, input bit sin, input bit lock);
        @(negedge clk);
        bus.we       = we;
        bus.waddr    = wa;
        bus.wdata    = wd;
        bus.scan_en  = sen;
        bus.scan_in  = sin;
        bus.cfg_lock = lock;
        @(posedge clk);
        #1;
        model_step(we, wa, wd, sen, sin, lock);
        drive_idle();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic shift(input bit sin);
        cycle(1'b0, '0, '0, 1'b1, sin, 1'b0);
    endtask

    task automatic reset_on();
        rst = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic reset_off();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_on();
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr = AW'(a);
            #1;
            checks++;
            if (bus.rdata !== 4'h0) begin
                errors++;
                $display("FAIL reset_rdata addr=%0d got=%h exp=0", a, bus.rdata);
            end
        end
        checks++;
        if (bus.scan_out !== 1'b0) begin errors++; $display("FAIL reset_scan_out got=%b exp=0", bus.scan_out); end
        checks++;
        if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.scan_busy); end
        checks++;
        if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.scan_done); end
        checks++;
        if (bus.crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc got=%h exp=00", bus.crc_out); end
        checks++;
        if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", bus.dbg_state); end
        reset_off();
    endtask

    task automatic test_write_read();
        cycle(1'b1, 4'd3, 4'hA, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr = AW'(a);
            #1;
            checks++;
            if (bus.rdata !== ((a == 3) ? 4'hA : 4'h0)) begin
                errors++;
                $display("FAIL write_read addr=%0d got=%h exp=%h", a, bus.rdata, (a == 3) ? 4'hA : 4'h0);
            end
            idle_cycle();
        end
    endtask

    task automatic test_scan_out();
        cycle(1'b1, 4'd15, 4'b1000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.scan_out !== 1'b1) begin errors++; $display("FAIL scan_out_before got=%b exp=1", bus.scan_out); end
        shift(1'b0);
        checks++;
        if (bus.scan_out !== 1'b0) begin errors++; $display("FAIL scan_out_after got=%b exp=0", bus.scan_out); end
        bus.raddr = 4'd0;
        #1;
        checks++;
        if (bus.rdata[0] !== 1'b0) begin errors++; $display("FAIL scan_head_bit got=%b exp=0", bus.rdata[0]); end
        // word3 held 1010, its top bit moved into word4 bit0
        bus.raddr = 4'd4;
        #1;
        checks++;
        if (bus.rdata !== 4'h1) begin errors++; $display("FAIL scan_carry word4 got=%h exp=1", bus.rdata); end
    endtask

    task automatic test_full_frame_ones();
        reset_on();
        reset_off();
        for (int k = 1; k <= TOTAL; k++) begin
            shift(1'b1);
            if (k < TOTAL) begin
                checks++;
                if (bus.scan_busy !== 1'b1 || bus.dbg_count !== CW'(k)) begin
                    errors++;
                    $display("FAIL ones_busy shift=%0d got busy=%b cnt=%0d exp busy=1 cnt=%0d",
                             k, bus.scan_busy, bus.dbg_count, k);
                end
            end
        end
        checks++;
        if (bus.scan_done !== 1'b1 || bus.scan_busy !== 1'b0) begin
            errors++;
            $display("FAIL ones_done got done=%b busy=%b exp done=1 busy=0", bus.scan_done, bus.scan_busy);
        end
        checks++;
        if (bus.crc_out !== crc_div(m_frame)) begin
            errors++;
            $display("FAIL ones_crc got=%h exp=%h", bus.crc_out, crc_div(m_frame));
        end
        idle_cycle();
        checks++;
        if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL ones_done_pulse got=%b exp=0", bus.scan_done); end
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr = AW'(a);
            #1;
            checks++;
            if (bus.rdata !== 4'hF) begin
                errors++;
                $display("FAIL ones_word addr=%0d got=%h exp=F", a, bus.rdata);
            end
            idle_cycle();
        end
    endtask

    task automatic test_pause();
        int dones;
        dones = 0;
        reset_on();
        reset_off();
        for (int k = 1; k <= TOTAL; k++) begin
            shift(1'b0);
            if (bus.scan_done === 1'b1) dones++;
            if (k == 32) begin
                for (int p = 0; p < 5; p++) begin
                    idle_cycle();
                    checks++;
                    if (bus.scan_busy !== 1'b1 || bus.dbg_count !== CW'(32)) begin
                        errors++;
                        $display("FAIL pause_hold got busy=%b cnt=%0d exp busy=1 cnt=32",
                                 bus.scan_busy, bus.dbg_count);
                    end
                end
            end
        end
        checks++;
        if (dones !== 1 || bus.scan_done !== 1'b1) begin
            errors++;
            $display("FAIL pause_done got dones=%0d done=%b exp dones=1 done=1", dones, bus.scan_done);
        end
        checks++;
        if (bus.crc_out !== 8'h00) begin errors++; $display("FAIL pause_crc got=%h exp=00", bus.crc_out); end
        idle_cycle();
    endtask

    task automatic test_priority();
        logic [7:0] crc_before;
        reset_on();
        reset_off();
        shift(1'b1);
        shift(1'b1);
        shift(1'b1);
        crc_before = crc_div(m_frame);
        cycle(1'b1, 4'd7, 4'h5, 1'b1, 1'b0, 1'b0);
        bus.raddr = 4'd7;
        #1;
        checks++;
        if (bus.rdata !== 4'h5) begin errors++; $display("FAIL prio_write got=%h exp=5", bus.rdata); end
        bus.raddr = 4'd0;
        #1;
        checks++;
        if (bus.rdata !== 4'h7) begin errors++; $display("FAIL prio_noshift word0 got=%h exp=7", bus.rdata); end
        checks++;
        if (bus.dbg_count !== CW'(3) || bus.crc_out !== crc_before) begin
            errors++;
            $display("FAIL prio_count got cnt=%0d crc=%h exp cnt=3 crc=%h", bus.dbg_count, bus.crc_out, crc_before);
        end
        cycle(1'b1, 4'd7, 4'hC, 1'b1, 1'b1, 1'b1);
        bus.raddr = 4'd7;
        #1;
        checks++;
        if (bus.rdata !== 4'h5) begin errors++; $display("FAIL lock_write got=%h exp=5", bus.rdata); end
        bus.raddr = 4'd0;
        #1;
        checks++;
        if (bus.rdata !== 4'h7) begin errors++; $display("FAIL lock_shift word0 got=%h exp=7", bus.rdata); end
        checks++;
        if (bus.dbg_count !== CW'(3) || bus.crc_out !== crc_before || bus.scan_busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_frame got cnt=%0d crc=%h busy=%b exp cnt=3 crc=%h busy=1",
                     bus.dbg_count, bus.crc_out, bus.scan_busy, crc_before);
        end
        // lock alone on a shift request must also block it
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.dbg_count !== CW'(3)) begin errors++; $display("FAIL lock_scan_only got cnt=%0d exp=3", bus.dbg_count); end
    endtask

    task automatic test_reset_mid();
        int dones;
        int done_at;
        reset_on();
        reset_off();
        for (int k = 0; k < 30; k++) shift(1'($urandom_range(0, 1)));
        reset_on();
        checks++;
        if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.scan_busy); end
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr = AW'(a);
            #1;
            checks++;
            if (bus.rdata !== 4'h0) begin
                errors++;
                $display("FAIL rstmid_word addr=%0d got=%h exp=0", a, bus.rdata);
            end
        end
        reset_off();
        dones   = 0;
        done_at = -1;
        for (int k = 1; k <= TOTAL; k++) begin
            shift(1'($urandom_range(0, 1)));
            if (bus.scan_done === 1'b1) begin dones++; done_at = k; end
        end
        idle_cycle();
        if (bus.scan_done === 1'b1) dones++;
        checks++;
        if (dones !== 1 || done_at !== TOTAL) begin
            errors++;
            $display("FAIL rstmid_frame got dones=%0d at=%0d exp dones=1 at=%0d", dones, done_at, TOTAL);
        end
        checks++;
        if (bus.crc_out !== crc_div(m_frame)) begin
            errors++;
            $display("FAIL rstmid_crc got=%h exp=%h", bus.crc_out, crc_div(m_frame));
        end
    endtask

    task automatic test_random();
        int          r;
        bit          we, sen, sin, lock;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        reset_on();
        reset_off();
        for (int i = 0; i < 700; i++) begin
            r    = $urandom_range(0, 99);
            wa   = AW'($urandom_range(0, DEPTH - 1));
            wd   = DW'($urandom_range(0, 15));
            sin  = 1'($urandom_range(0, 1));
            we   = (r >= 65 && r < 82);
            sen  = (r < 65) || (r >= 75 && r < 82) || (r >= 82 && r < 90 && sin);
            lock = (r >= 82 && r < 90);
            if (lock) we = 1'($urandom_range(0, 1));
            cycle(we, wa, wd, sen, sin, lock);
            ra = AW'($urandom_range(0, DEPTH - 1));
            bus.raddr = ra;
            #1;
            checks++;
            if (bus.rdata !== m_mem[ra]) begin
                errors++;
                $display("FAIL rand_rdata cyc=%0d addr=%0d got=%h exp=%h", i, ra, bus.rdata, m_mem[ra]);
            end
            checks++;
            if (bus.scan_out !== m_mem[DEPTH-1][DW-1]) begin
                errors++;
                $display("FAIL rand_scan_out cyc=%0d got=%b exp=%b", i, bus.scan_out, m_mem[DEPTH-1][DW-1]);
            end
            checks++;
            if (bus.scan_busy !== m_active || bus.scan_done !== m_done) begin
                errors++;
                $display("FAIL rand_status cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                         i, bus.scan_busy, bus.scan_done, m_active, m_done);
            end
            checks++;
            if (bus.dbg_count !== CW'(m_count())) begin
                errors++;
                $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.dbg_count, m_count());
            end
            checks++;
            if (bus.crc_out !== crc_div(m_frame)) begin
                errors++;
                $display("FAIL rand_crc cyc=%0d got=%h exp=%h", i, bus.crc_out, crc_div(m_frame));
            end
        end
        for (int a = 0; a < DEPTH; a++) exp_q.push_back(m_mem[a]);
        for (int a = 0; a < DEPTH; a++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            bus.raddr = AW'(a);
            #1;
            checks++;
            if (bus.rdata !== e) begin
                errors++;
                $display("FAIL rand_final addr=%0d got=%h exp=%h", a, bus.rdata, e);
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- sequence + report ----------------
    initial begin
        bus.raddr = '0;
        drive_idle();
        model_reset();
        test_reset();
        test_write_read();
        test_scan_out();
        test_full_frame_ones();
        test_pause();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cfg_sram_array
